// File: rtl/inv_round_iter_pkg.sv
// Shared definitions for the iterative inverse-round decryptor.
// One cipher round is y = rotl((x ^ {4{k}}) + RoundConst, RotAmt).
package inv_round_iter_pkg;

  parameter int unsigned DefaultRounds = 16;
  localparam int unsigned BlockW = 32;
  localparam int unsigned KeyW = 8;

  localparam logic [BlockW-1:0] RoundConst = 32'h9E3779B9;
  localparam int unsigned RotAmt = 5;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHold = 2'd2
  } state_e;

endpackage

// File: rtl/inv_round_iter_if.sv
// Request/key/result bundle for inv_round_iter; slave is the core side.
interface inv_round_iter_if #(
    parameter int unsigned AddrW = 4
);
    logic             start;
    logic [31:0]      c_in;
    logic             ready;
    logic [AddrW-1:0] k_addr;
    logic [7:0]       k_in;
    logic [31:0]      p_out;
    logic             out_valid;
    logic             out_ack;

    modport slave (
        input  start, c_in, k_in, out_ack,
        output ready, k_addr, p_out, out_valid
    );

    modport master (
        output start, c_in, k_in, out_ack,
        input  ready, k_addr, p_out, out_valid
    );
endinterface

// File: rtl/inv_round_iter_inv_round.sv
// Combinational single inverse round: undoes rotate, then add, then key XOR.
module inv_round_iter_inv_round
    import inv_round_iter_pkg::*;
(
    input  logic [BlockW-1:0] d_i,
    input  logic [KeyW-1:0]   k_i,
    output logic [BlockW-1:0] d_o
);
    logic [BlockW-1:0] rot;

    always_comb begin
        rot = {d_i[RotAmt-1:0], d_i[BlockW-1:RotAmt]};
        d_o = (rot - RoundConst) ^ {4{k_i}};
    end
endmodule

// File: rtl/inv_round_iter.sv
// Iterative decryptor: one inverse round per clock, round keys fetched last-to-first.
module inv_round_iter
    import inv_round_iter_pkg::*;
#(
    parameter int unsigned NumRounds = DefaultRounds,
    parameter int unsigned AddrW     = (NumRounds > 1) ? $clog2(NumRounds) : 1
) (
    input logic              clk,
    input logic              rst,
    inv_round_iter_if.slave  bus
);
    localparam logic [AddrW-1:0] LastIdx = AddrW'(NumRounds - 1);

    state_e            state_q, state_d;
    logic [AddrW-1:0]  cnt_q, cnt_d;
    logic [BlockW-1:0] data_q, data_d;
    logic [BlockW-1:0] p_out_q, p_out_d;
    logic              valid_q, valid_d;
    logic [BlockW-1:0] round_out;

    inv_round_iter_inv_round u_inv_round (
        .d_i (data_q),
        .k_i (bus.k_in),
        .d_o (round_out)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        p_out_d = p_out_q;
        valid_d = valid_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    data_d  = bus.c_in;
                    cnt_d   = LastIdx;
                    state_d = StRun;
                end
            end
            StRun: begin
                data_d = round_out;
                // Compare before decrementing so the counter never wraps.
                if (cnt_q == '0) begin
                    p_out_d = round_out;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q - AddrW'(1);
                end
            end
            StHold: begin
                if (bus.out_ack) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            data_q  <= '0;
            p_out_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            p_out_q <= p_out_d;
            valid_q <= valid_d;
        end
    end

    // The round counter doubles as the key address.
    assign bus.ready     = (state_q == StIdle);
    assign bus.k_addr    = cnt_q;
    assign bus.p_out     = p_out_q;
    assign bus.out_valid = valid_q;
endmodule
